// File: rtl/wb_uart_pkg.sv
// Shared register map, status bit positions and serializer states for wb_uart_tx.
package wb_uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous FIFO with wrap-around pointers and a separate occupancy counter.
module wb_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone transmit-only UART: TX FIFO, programmable baud divisor, status and irq.
// Define WB_UART_TX_PARITY_EN to insert an even-parity bit (8E1 instead of 8N1).
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int          WB_DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          DIV_WIDTH     = 16,
  parameter int unsigned DIV_RESET     = 434
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst_n,
  input  logic [WB_DATA_WIDTH-1:0]   wb_adr,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat,
  input  logic [WB_DATA_WIDTH/8-1:0] wb_sel,
  input  logic                       wb_we,
  input  logic                       wb_cyc,
  output logic [WB_DATA_WIDTH-1:0]   wb_rdt,
  output logic                       wb_ack,
  output logic                       tx,
  output logic                       irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t       state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_wr;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 par;
  logic                 ovf_q;
  logic                 line;
  logic                 boundary;
  logic                 busy;
  logic                 req;
  logic [1:0]           adr;
  logic                 push;
  logic                 pop;
  logic [7:0]           fifo_rdata;
  logic                 full;
  logic                 empty;
  logic [LW-1:0]        level;
  logic [WB_DATA_WIDTH-1:0] status;
  logic                 unused_bits;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
    return (v == '0) ? DIV_WIDTH'(1) : v;
  endfunction

  assign unused_bits = ^{wb_adr, wb_dat, wb_sel};
  assign req      = wb_cyc & ~wb_ack;
  assign adr      = wb_adr[3:2];
  assign push     = req & wb_we & (adr == ADDR_DATA) & wb_sel[0];
  assign boundary = (cnt == '0);
  assign busy     = (state != IDLE);
  assign irq      = empty & ~busy;
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & boundary));

  wb_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wb_dat[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    div_wr = div_q;
    for (int b = 0; b < DIV_WIDTH; b++)
      if (wb_sel[b/8]) div_wr[b] = wb_dat[b];
  end

  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf_q;
    status[ST_LEVEL_LSB +: 8] = 8'(level);
    wb_rdt = '0;
    case (adr)
      ADDR_STATUS: wb_rdt = status;
      ADDR_DIV:    wb_rdt[DIV_WIDTH-1:0] = div_q;
      default:     wb_rdt = '0;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_ack <= 1'b0;
      div_q  <= DIV_WIDTH'(DIV_RESET);
      ovf_q  <= 1'b0;
    end else begin
      wb_ack <= wb_cyc & ~wb_ack;
      if (req & wb_we & (adr == ADDR_DIV)) div_q <= clamp_div(div_wr);
      if (push & full & ~pop)
        ovf_q <= 1'b1;
      else if (req & ~wb_we & (adr == ADDR_STATUS))
        ovf_q <= 1'b0;
    end
  end

  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
      PARITY:  line = par;
      default: line = 1'b1;
    endcase
  end

  // tx is the registered line value, so the wire lags the state by one clock.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      div_lat <= DIV_WIDTH'(DIV_RESET);
      tx      <= 1'b1;
    end else begin
      tx <= line;
      case (state)
        IDLE: begin
          if (!empty) begin
            state   <= START;
            div_lat <= div_q;
            cnt     <= div_q - 1'b1;
          end
        end
        START: begin
          if (boundary) begin
            state   <= DATA;
            bit_cnt <= '0;
            cnt     <= div_lat - 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        DATA: begin
          if (boundary) begin
            cnt <= div_lat - 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else bit_cnt <= bit_cnt + 1'b1;
          end else cnt <= cnt - 1'b1;
        end
`ifdef WB_UART_TX_PARITY_EN
        PARITY: begin
          if (boundary) begin
            state <= STOP;
            cnt   <= div_lat - 1'b1;
          end else cnt <= cnt - 1'b1;
        end
`endif
        STOP: begin
          if (boundary) begin
            // Back-to-back frames: the divisor is re-latched here, never mid-frame.
            if (!empty) begin
              state   <= START;
              div_lat <= div_q;
              cnt     <= div_q - 1'b1;
            end else state <= IDLE;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (pop) begin
      shift <= fifo_rdata;
      par   <= ^fifo_rdata;
    end else if ((state == DATA) && boundary) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule
